// File: rtl/mem_access_ctl_pkg.sv
// Shared types for the load/store access controller: access/exception codes,
// FSM state encoding and the alignment rule.
package mem_access_ctl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic {
        MEM_ACCESS_R = 1'b0,
        MEM_ACCESS_W = 1'b1
    } MEM_ACCESS_T;

    typedef enum logic [1:0] {
        MMU_EXCEPTION_NONE       = 2'd0,
        MMU_EXCEPTION_TLBMISS    = 2'd1,
        MMU_EXCEPTION_TLBINVALID = 2'd2,
        MMU_EXCEPTION_TLBMOD     = 2'd3
    } MMU_EXCEPTION_T;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } MEM_SIZE_T;

    typedef enum logic [2:0] {
        MEM_EXC_NONE   = 3'd0,
        MEM_EXC_ADEL   = 3'd1,
        MEM_EXC_ADES   = 3'd2,
        MEM_EXC_MMU    = 3'd3,
        MEM_EXC_BUSERR = 3'd4
    } MEM_EXC_T;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XLATE = 3'd1,
        ST_CHECK = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4
    } ctl_state_t;

    // Size code 3 is reserved and always faults; halves need addr[0]=0,
    // words need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lo[0];
            2'd2:    mis = (lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_ctl_if.sv
// CPU request/response, MMU translation and memory bus signals of the
// access controller. master = controller side, slave = its environment.
interface mem_access_ctl_if;
    import mem_access_ctl_pkg::*;

    // CPU request / response
    logic           req_valid;
    logic           req_ready;
    logic [31:0]    req_addr;
    MEM_ACCESS_T    req_type;
    logic [1:0]     req_size;
    logic           req_signed;
    logic [31:0]    req_wdata;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    MEM_EXC_T       resp_exc;
    MMU_EXCEPTION_T resp_mmuExc;

    // MMU translation
    logic           mmu_addrValid;
    logic [31:0]    mmu_vAddr;
    MEM_ACCESS_T    mmu_accessType;
    logic [31:0]    mmu_pAddr;
    MMU_EXCEPTION_T mmu_exception;

    // Physical memory bus
    logic           bus_req;
    logic           bus_we;
    logic [31:0]    bus_addr;
    logic [3:0]     bus_be;
    logic [31:0]    bus_wdata;
    logic           bus_ack;
    logic [31:0]    bus_rdata;

    modport master (
        input  req_valid, req_addr, req_type, req_size, req_signed, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_exc, resp_mmuExc,
        output mmu_addrValid, mmu_vAddr, mmu_accessType,
        input  mmu_pAddr, mmu_exception,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        output req_valid, req_addr, req_type, req_size, req_signed, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc, resp_mmuExc,
        input  mmu_addrValid, mmu_vAddr, mmu_accessType,
        output mmu_pAddr, mmu_exception,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_ctl_lane.sv
// Byte-lane steering: byte enables, store data replication and load data
// shift plus zero/sign extension. Purely combinational.
module mem_lane
    import mem_access_ctl_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    // Lane selection and load extension by access size
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (size)
            MEM_SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
            end
            MEM_SIZE_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
            end
            MEM_SIZE_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctl.sv
// Load/store access controller: alignment check, MMU translation, one bus
// access with timeout, single response back to the pipeline.
module mem_access_ctl
    import mem_access_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             res,
    mem_access_ctl_if.master mif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ctl_state_t     state_q, state_d;

    logic [31:0]    addr_q;
    MEM_ACCESS_T    type_q;
    logic [1:0]     size_q;
    logic           signed_q;
    logic [31:0]    wdata_q;
    logic [31:0]    paddr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]    rdata_q;
    MEM_EXC_T       exc_q;
    MMU_EXCEPTION_T mmuexc_q;

    logic           req_mis;
    logic           mmu_fault;
    logic           cnt_last;
    logic [3:0]     lane_be;
    logic [31:0]    lane_wdata;
    logic [31:0]    lane_rdata;

    assign req_mis   = is_misaligned(mif.req_size, mif.req_addr[1:0]);
    assign mmu_fault = (mif.mmu_exception != MMU_EXCEPTION_NONE);
    assign cnt_last  = (cnt_q == CNT_LAST);

    mem_lane u_lane (
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .sgn       (signed_q),
        .wdata     (wdata_q),
        .rdata     (mif.bus_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // State register; reset aborts any access in flight without a response
    always_ff @(posedge clk) begin
        if (!res) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; ack beats the final timeout count
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (mif.req_valid) state_d = req_mis ? ST_RESP : ST_XLATE;
            ST_XLATE: state_d = ST_CHECK;
            ST_CHECK: state_d = mmu_fault ? ST_RESP : ST_BUS;
            ST_BUS:   if (mif.bus_ack || cnt_last) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes and bus drive decoded from state; bus fields only live in BUS
    always_comb begin
        mif.req_ready     = 1'b0;
        mif.resp_valid    = 1'b0;
        mif.mmu_addrValid = 1'b0;
        mif.bus_req       = 1'b0;
        mif.bus_we        = 1'b0;
        mif.bus_be        = 4'b0000;
        mif.bus_wdata     = 32'h0;
        case (state_q)
            ST_IDLE:  mif.req_ready     = 1'b1;
            ST_XLATE: mif.mmu_addrValid = 1'b1;
            ST_BUS: begin
                mif.bus_req   = 1'b1;
                mif.bus_we    = (type_q == MEM_ACCESS_W);
                mif.bus_be    = lane_be;
                mif.bus_wdata = lane_wdata;
            end
            ST_RESP:  mif.resp_valid    = 1'b1;
            default:  ;
        endcase
    end

    assign mif.mmu_vAddr      = addr_q;
    assign mif.mmu_accessType = type_q;
    assign mif.bus_addr       = {paddr_q[31:2], 2'b00};
    assign mif.resp_rdata     = rdata_q;
    assign mif.resp_exc       = exc_q;
    assign mif.resp_mmuExc    = mmuexc_q;

    // Request latch, translation capture, timeout counter and response data
    always_ff @(posedge clk) begin
        if (!res) begin
            addr_q   <= 32'h0;
            type_q   <= MEM_ACCESS_R;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            wdata_q  <= 32'h0;
            paddr_q  <= 32'h0;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
            exc_q    <= MEM_EXC_NONE;
            mmuexc_q <= MMU_EXCEPTION_NONE;
        end else begin
            case (state_q)
                ST_IDLE: if (mif.req_valid) begin
                    addr_q   <= mif.req_addr;
                    type_q   <= mif.req_type;
                    size_q   <= mif.req_size;
                    signed_q <= mif.req_signed;
                    wdata_q  <= mif.req_wdata;
                    rdata_q  <= 32'h0;
                    mmuexc_q <= MMU_EXCEPTION_NONE;
                    if (!req_mis)                            exc_q <= MEM_EXC_NONE;
                    else if (mif.req_type == MEM_ACCESS_W)   exc_q <= MEM_EXC_ADES;
                    else                                     exc_q <= MEM_EXC_ADEL;
                end
                ST_CHECK: begin
                    if (mmu_fault) begin
                        exc_q    <= MEM_EXC_MMU;
                        mmuexc_q <= mif.mmu_exception;
                    end else begin
                        paddr_q <= mif.mmu_pAddr;
                        cnt_q   <= '0;
                    end
                end
                ST_BUS: begin
                    if (mif.bus_ack) begin
                        exc_q   <= MEM_EXC_NONE;
                        rdata_q <= (type_q == MEM_ACCESS_R) ? lane_rdata : 32'h0;
                    end else if (cnt_last) begin
                        exc_q <= MEM_EXC_BUSERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctl.sv
// Directed bench: behavioural MMU (VPN2=2, PFN=20 on the even page) and a
// bus model acking after a programmable number of wait cycles.
module tb_mem_access_ctl;
    import mem_access_ctl_pkg::*;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    // results of the last transaction
    int          lat;
    int          n_bus;
    int          n_xlate;
    logic [31:0] r_rdata;
    logic [2:0]  r_exc;
    logic [1:0]  r_mmuexc;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wdata;

    mem_access_ctl_if mif();

    mem_access_ctl #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .res (res),
        .mif (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // MMU model: even 4K page of VPN2=2 maps to PFN 20, everything else misses
    task automatic mmu_model();
        if (mif.mmu_addrValid) begin
            if (mif.mmu_vAddr[31:12] == 20'h00004) begin
                mif.mmu_pAddr     = {20'd20, mif.mmu_vAddr[11:0]};
                mif.mmu_exception = MMU_EXCEPTION_NONE;
            end else begin
                mif.mmu_pAddr     = 32'hFFFF_FFFF;
                mif.mmu_exception = MMU_EXCEPTION_TLBMISS;
            end
        end
    endtask

    task automatic run_req(input logic [31:0] addr, input MEM_ACCESS_T typ, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int delay, input logic ack_en);
        int wcnt = 0;
        lat = 0; n_bus = 0; n_xlate = 0;
        r_rdata = 32'hX; r_exc = 3'h7; r_mmuexc = 2'h3;
        cap_addr = 32'h0; cap_be = 4'h0; cap_we = 1'b0; cap_wdata = 32'h0;
        @(negedge clk);
        mif.mmu_exception = MMU_EXCEPTION_TLBINVALID;
        mif.req_valid  = 1'b1;
        mif.req_addr   = addr;
        mif.req_type   = typ;
        mif.req_size   = size;
        mif.req_signed = sgn;
        mif.req_wdata  = wdata;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            mif.req_valid = 1'b0;
            mmu_model();
            if (mif.mmu_addrValid) n_xlate++;
            if (mif.bus_req) begin
                n_bus++;
                cap_addr  = mif.bus_addr;
                cap_be    = mif.bus_be;
                cap_we    = mif.bus_we;
                cap_wdata = mif.bus_wdata;
                mif.bus_rdata = rdata;
                mif.bus_ack   = ack_en && (wcnt == delay);
                wcnt++;
            end else begin
                mif.bus_ack = 1'b0;
                wcnt = 0;
            end
            if (mif.resp_valid) begin
                lat      = cyc;
                r_rdata  = mif.resp_rdata;
                r_exc    = mif.resp_exc;
                r_mmuexc = mif.resp_mmuExc;
                break;
            end
        end
        if (lat == 0) begin
            n_chk++; n_err++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 40 cycles");
        end
    endtask

    initial begin
        int seen;
        mif.req_valid = 1'b0; mif.req_addr = 32'h0; mif.req_type = MEM_ACCESS_R;
        mif.req_size = 2'd0; mif.req_signed = 1'b0; mif.req_wdata = 32'h0;
        mif.mmu_pAddr = 32'h0; mif.mmu_exception = MMU_EXCEPTION_NONE;
        mif.bus_ack = 1'b0; mif.bus_rdata = 32'h0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   32'(mif.req_ready), 32'd1);
        chk("rst_resp_v",  32'(mif.resp_valid), 32'd0);
        chk("rst_rdata",   mif.resp_rdata, 32'h0);
        chk("rst_exc",     32'(mif.resp_exc), 32'(MEM_EXC_NONE));
        chk("rst_mmu_v",   32'(mif.mmu_addrValid), 32'd0);
        chk("rst_vaddr",   mif.mmu_vAddr, 32'h0);
        chk("rst_bus_req", 32'(mif.bus_req), 32'd0);
        chk("rst_bus_ctl", {mif.bus_addr[31:5], mif.bus_we, mif.bus_be}, 32'h0);
        chk("rst_wdata",   mif.bus_wdata, 32'h0);
        res = 1'b1;

        // word read, zero wait
        run_req(32'h0000_4010, MEM_ACCESS_R, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
        chk("wr_lat",   32'(lat), 32'd4);
        chk("wr_addr",  cap_addr, 32'h0001_4010);
        chk("wr_be",    32'(cap_be), 32'hF);
        chk("wr_we",    32'(cap_we), 32'd0);
        chk("wr_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("wr_exc",   32'(r_exc), 32'(MEM_EXC_NONE));

        // signed / unsigned byte read on lane 3, one wait cycle
        run_req(32'h0000_4013, MEM_ACCESS_R, 2'd0, 1'b1, 32'h0, 32'h80FF_FFFF, 1, 1'b1);
        chk("bs_lat",   32'(lat), 32'd5);
        chk("bs_be",    32'(cap_be), 32'h8);
        chk("bs_addr",  cap_addr, 32'h0001_4010);
        chk("bs_rdata", r_rdata, 32'hFFFF_FF80);
        run_req(32'h0000_4013, MEM_ACCESS_R, 2'd0, 1'b0, 32'h0, 32'h80FF_FFFF, 0, 1'b1);
        chk("bu_rdata", r_rdata, 32'h0000_0080);

        // byte read on lane 1, signed half read upper
        run_req(32'h0000_4021, MEM_ACCESS_R, 2'd0, 1'b0, 32'h0, 32'h1122_A344, 0, 1'b1);
        chk("b1_be",    32'(cap_be), 32'h2);
        chk("b1_rdata", r_rdata, 32'h0000_00A3);
        run_req(32'h0000_4022, MEM_ACCESS_R, 2'd1, 1'b1, 32'h0, 32'h8001_1234, 0, 1'b1);
        chk("hs_be",    32'(cap_be), 32'hC);
        chk("hs_rdata", r_rdata, 32'hFFFF_8001);

        // half write upper
        run_req(32'h0000_4012, MEM_ACCESS_W, 2'd1, 1'b0, 32'h0000_ABCD, 32'h5555_5555, 0, 1'b1);
        chk("hw_we",    32'(cap_we), 32'd1);
        chk("hw_be",    32'(cap_be), 32'hC);
        chk("hw_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("hw_rdata", r_rdata, 32'h0);
        chk("hw_exc",   32'(r_exc), 32'(MEM_EXC_NONE));

        // byte write lane 0
        run_req(32'h0000_4000, MEM_ACCESS_W, 2'd0, 1'b0, 32'h1234_5677, 32'h0, 0, 1'b1);
        chk("bw_be",    32'(cap_be), 32'h1);
        chk("bw_wdata", cap_wdata, 32'h7777_7777);

        // misaligned: no MMU or bus activity, response in the 1st cycle
        run_req(32'h0000_4011, MEM_ACCESS_R, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        chk("adel_exc",  32'(r_exc), 32'(MEM_EXC_ADEL));
        chk("adel_lat",  32'(lat), 32'd1);
        chk("adel_act",  32'(n_xlate + n_bus), 32'd0);
        run_req(32'h0000_4011, MEM_ACCESS_W, 2'd1, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        chk("ades_exc",  32'(r_exc), 32'(MEM_EXC_ADES));
        chk("ades_act",  32'(n_xlate + n_bus), 32'd0);
        run_req(32'h0000_4010, MEM_ACCESS_R, 2'd3, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        chk("sz3_exc",   32'(r_exc), 32'(MEM_EXC_ADEL));

        // unmapped page: MMU exception in the 3rd cycle, no bus
        run_req(32'h000C_0000, MEM_ACCESS_R, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        chk("mmu_exc",   32'(r_exc), 32'(MEM_EXC_MMU));
        chk("mmu_code",  32'(r_mmuexc), 32'(MMU_EXCEPTION_TLBMISS));
        chk("mmu_lat",   32'(lat), 32'd3);
        chk("mmu_bus",   32'(n_bus), 32'd0);

        // timeout: bus_req for exactly 4 cycles, then BUSERR
        run_req(32'h0000_4010, MEM_ACCESS_R, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        chk("to_bus",    32'(n_bus), 32'd4);
        chk("to_exc",    32'(r_exc), 32'(MEM_EXC_BUSERR));
        chk("to_lat",    32'(lat), 32'd7);

        // ack on the final count wins over timeout
        run_req(32'h0000_4010, MEM_ACCESS_R, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 3, 1'b1);
        chk("last_exc",   32'(r_exc), 32'(MEM_EXC_NONE));
        chk("last_rdata", r_rdata, 32'hCAFE_F00D);
        chk("last_lat",   32'(lat), 32'd7);

        // reset during BUS aborts with no response
        @(negedge clk);
        mif.req_valid = 1'b1; mif.req_addr = 32'h0000_4010; mif.req_type = MEM_ACCESS_R;
        mif.req_size = 2'd2; mif.req_signed = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            mif.req_valid = 1'b0;
            mif.bus_ack   = 1'b0;
            mmu_model();
            if (mif.bus_req) begin seen = 1; break; end
        end
        chk("ra_reached_bus", 32'(seen), 32'd1);
        res = 1'b0;
        @(posedge clk);
        #1;
        chk("ra_bus_req", 32'(mif.bus_req), 32'd0);
        chk("ra_ready",   32'(mif.req_ready), 32'd1);
        @(negedge clk);
        res = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (mif.resp_valid) seen++;
        end
        chk("ra_no_resp", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
